// File: rtl/ct_pkg.sv
// rtl/ct_pkg.sv - shared constants and ciphertext types for the BFV/RLWE datapath
package ct_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS_L  = 16;
  localparam logic [W_BITS_L-1:0] Q_MOD = 16'd7710;
  localparam int T_MOD = 257;
  localparam int DELTA = 30;

  // Slot 0 lives in the least significant W bits.
  typedef logic [N_SLOTS_L-1:0][W_BITS_L-1:0] vec_t;

  typedef struct packed {
    vec_t A;
    vec_t B;
  } CT_t;

endpackage

// File: rtl/mod_add.sv
// rtl/mod_add.sv - combinational single-slot (a + b) mod QP
module mod_add #(
  parameter int W = 16,
  parameter logic [W-1:0] QP = 16'd7710
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] s;
  logic [W:0] r;

  // One conditional subtraction suffices when both operands are below QP.
  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    r = (s >= {1'b0, QP}) ? (s - {1'b0, QP}) : s;
  end

  assign y = r[W-1:0];

endmodule

// File: rtl/ct_ct_add_reg.sv
// rtl/ct_ct_add_reg.sv - registered ciphertext + ciphertext adder; CT_ADD_RANGE_CHK_EN adds range_err
module ct_ct_add_reg
  import ct_pkg::*;
#(
  parameter logic [W_BITS_L-1:0] QP = Q_MOD
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  CT_t  in_ct1,
  input  CT_t  in_ct2,
  output logic out_valid,
  output CT_t  out_ct
`ifdef CT_ADD_RANGE_CHK_EN
  ,
  output logic range_err
`endif
);

  CT_t  sum_ct;
  CT_t  out_ct_d, out_ct_q;
  logic out_valid_d, out_valid_q;

  for (genvar i = 0; i < N_SLOTS_L; i++) begin : g_slot
    mod_add #(.W(W_BITS_L), .QP(QP)) u_add_a (
      .a(in_ct1.A[i]),
      .b(in_ct2.A[i]),
      .y(sum_ct.A[i])
    );
    mod_add #(.W(W_BITS_L), .QP(QP)) u_add_b (
      .a(in_ct1.B[i]),
      .b(in_ct2.B[i]),
      .y(sum_ct.B[i])
    );
  end

  always_comb begin
    out_valid_d = in_valid;
    out_ct_d    = in_valid ? sum_ct : out_ct_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ct_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ct_q    <= out_ct_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ct    = out_ct_q;

`ifdef CT_ADD_RANGE_CHK_EN
  logic any_ge;
  logic range_err_d, range_err_q;

  always_comb begin
    any_ge = 1'b0;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      if ((in_ct1.A[i] >= QP) || (in_ct1.B[i] >= QP) ||
          (in_ct2.A[i] >= QP) || (in_ct2.B[i] >= QP)) begin
        any_ge = 1'b1;
      end
    end
    range_err_d = in_valid ? any_ge : range_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign range_err = range_err_q;
`endif

endmodule

// File: tb/tb_ct_ct_add_reg.sv
// tb/tb_ct_ct_add_reg.sv - scoreboard bench for ct_ct_add_reg (CT_ADD_RANGE_CHK_EN optional)
module tb_ct_ct_add_reg;
  import ct_pkg::*;

  localparam int QPI = 7710;

  typedef struct {
    logic valid;
    CT_t  ct;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  CT_t  in_ct1, in_ct2;
  logic out_valid;
  CT_t  out_ct;
  logic range_err_obs;

`ifdef CT_ADD_RANGE_CHK_EN
  logic range_err;
  assign range_err_obs = range_err;
`else
  assign range_err_obs = 1'b0;
`endif

  ct_ct_add_reg dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ct1   (in_ct1),
    .in_ct2   (in_ct2),
    .out_valid(out_valid),
    .out_ct   (out_ct)
`ifdef CT_ADD_RANGE_CHK_EN
    ,
    .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  CT_t  last_ct;
  logic last_err;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic CT_t model(input CT_t a, input CT_t b);
    CT_t r;
    int  s;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      s = int'(a.A[i]) + int'(b.A[i]);
      if (s >= QPI) s = s - QPI;
      r.A[i] = W_BITS_L'(s);
      s = int'(a.B[i]) + int'(b.B[i]);
      if (s >= QPI) s = s - QPI;
      r.B[i] = W_BITS_L'(s);
    end
    return r;
  endfunction

  function automatic logic model_err(input CT_t a, input CT_t b);
    logic e = 1'b0;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      if (int'(a.A[i]) >= QPI || int'(a.B[i]) >= QPI ||
          int'(b.A[i]) >= QPI || int'(b.B[i]) >= QPI) e = 1'b1;
    end
    return e;
  endfunction

  function automatic CT_t fill(input int v);
    CT_t r;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      r.A[i] = W_BITS_L'(v);
      r.B[i] = W_BITS_L'(v);
    end
    return r;
  endfunction

  function automatic CT_t rnd_ct();
    CT_t r;
    for (int i = 0; i < N_SLOTS_L; i++) begin
      r.A[i] = W_BITS_L'($urandom_range(0, QPI - 1));
      r.B[i] = W_BITS_L'($urandom_range(0, QPI - 1));
    end
    return r;
  endfunction

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic step(input string tag, input logic r, input logic v, input CT_t a, input CT_t b);
    exp_t e, o;
    rst = r; in_valid = v; in_ct1 = a; in_ct2 = b;
    if (r) begin
      e.valid = 1'b0; e.ct = '0; e.err = 1'b0;
    end else if (v) begin
      e.valid = 1'b1; e.ct = model(a, b); e.err = model_err(a, b);
    end else begin
      e.valid = 1'b0; e.ct = last_ct; e.err = last_err;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check({tag, ".valid"}, 256'(out_valid), 256'(o.valid));
    check({tag, ".ct"}, 256'(out_ct), 256'(o.ct));
`ifdef CT_ADD_RANGE_CHK_EN
    check({tag, ".err"}, 256'(range_err_obs), 256'(o.err));
`endif
    last_ct = o.ct; last_err = o.err;
  endtask

  initial begin
    int  a1[8] = '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973};
    int  a2[8] = '{1081, 592, 951, 5762, 2873, 4, 152, 3013};
    int  ea[8] = '{2510, 5309, 7262, 1331, 2378, 6219, 7083, 3986};
    int  b1[8] = '{7531, 4381, 1094, 7529, 5909, 964, 5576, 4640};
    int  b2[8] = '{1577, 3917, 6039, 6187, 2056, 6280, 1531, 7656};
    int  eb[8] = '{1398, 588, 7133, 6006, 255, 7244, 7107, 4586};
    CT_t c1, c2, cexp, h0, h1, h2, h3;

    last_ct = '0; last_err = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_ct1 = '0; in_ct2 = '0;
    step("reset0", 1'b1, 1'b0, '0, '0);
    step("reset_in_valid", 1'b1, 1'b1, fill(1234), fill(99));

    for (int i = 0; i < N_SLOTS_L; i++) begin
      c1.A[i] = W_BITS_L'(a1[i]); c2.A[i] = W_BITS_L'(a2[i]); cexp.A[i] = W_BITS_L'(ea[i]);
      c1.B[i] = W_BITS_L'(b1[i]); c2.B[i] = W_BITS_L'(b2[i]); cexp.B[i] = W_BITS_L'(eb[i]);
    end
    step("fixed", 1'b0, 1'b1, c1, c2);
    check("fixed.const", 256'(out_ct), 256'(cexp));

    step("wrap_q", 1'b0, 1'b1, fill(7709), fill(1));
    check("wrap_q.const", 256'(out_ct), 256'(fill(0)));
    step("wrap_qm1", 1'b0, 1'b1, fill(7709), fill(0));
    check("wrap_qm1.const", 256'(out_ct), 256'(fill(7709)));
    step("wrap_max", 1'b0, 1'b1, fill(7709), fill(7709));
    check("wrap_max.const", 256'(out_ct), 256'(fill(7708)));
    step("wrap_half", 1'b0, 1'b1, fill(3855), fill(3855));
    check("wrap_half.const", 256'(out_ct), 256'(fill(0)));
    step("wrap_zero", 1'b0, 1'b1, fill(0), fill(0));

    h0 = rnd_ct(); h1 = rnd_ct(); h2 = rnd_ct(); h3 = rnd_ct();
    step("hs0", 1'b0, 1'b1, h0, h1);
    step("hs1", 1'b0, 1'b1, h2, h3);
    step("hs2_idle", 1'b0, 1'b0, h1, h0);
    step("hs3", 1'b0, 1'b1, h3, h0);

    for (int k = 0; k < 8; k++) step("rand", 1'b0, ($urandom_range(0, 3) != 0), rnd_ct(), rnd_ct());

    step("pre_rst", 1'b0, 1'b1, fill(500), fill(600));
    step("rst_after", 1'b1, 1'b0, fill(7), fill(8));
    step("post_rst_idle", 1'b0, 1'b0, fill(7), fill(8));

`ifdef CT_ADD_RANGE_CHK_EN
    c1 = fill(100);
    c1.A[3] = 16'd7710;
    step("rng_set", 1'b0, 1'b1, c1, fill(5));
    check("rng_set.const", 256'(range_err_obs), 256'(1'b1));
    step("rng_hold", 1'b0, 1'b0, fill(1), fill(1));
    step("rng_clr", 1'b0, 1'b1, fill(100), fill(5));
    check("rng_clr.const", 256'(range_err_obs), 256'(1'b0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_ct_add_reg.md
Name: ct_ct_add_reg

Overview:
- Registered ciphertext + ciphertext adder for the BFV/RLWE datapath.
- Each ciphertext is a pair of N-slot coefficient vectors (A, B).
- Output is slot-wise (in_ct1 + in_ct2) mod QP on both vectors, one cycle after the input is accepted.
- Sits between the ciphertext register file and downstream homomorphic ops (ct-pt mult, relinearisation).

Parameters:
- N, 8 (N_SLOTS_L): coefficient slots per vector.
- W, 16 (W_BITS_L): bits per coefficient.
- QP, 16'd7710: ciphertext modulus q. Legal range is 2 ≤ QP < 2^W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_ct1/in_ct2 valid this cycle.
- in_ct1  input  CT_t (2*N*W)  ciphertext operand 1.
- in_ct2  input  CT_t (2*N*W)  ciphertext operand 2.
- out_valid  output  1  out_ct holds a new result.
- out_ct  output  CT_t (2*N*W)  registered modular sum.
- range_err  output  1  present only when CT_ADD_RANGE_CHK_EN is defined.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high on clk.
- While rst=1 at a rising edge: out_ct <= 0, out_valid <= 0, range_err <= 0. rst has priority over in_valid.
- Reset asserted mid-operation discards any result in flight. No result emerges after reset.
- Latency: exactly 1 cycle.
  - in_valid=1 at edge k → out_valid=1 and out_ct valid after edge k.
  - in_valid=0 at an edge → out_valid <= 0 and out_ct holds its previous value.
- Throughput: one operation per cycle. No backpressure, no ready signal. Back-to-back inputs give back-to-back outputs.
- Arithmetic, per slot i in 0..N-1, for both A and B:
  - s = {1'b0,a[i]} + {1'b0,b[i]}, computed in W+1 bits so nothing is lost.
  - out[i] = (s >= QP) ? s - QP : s, truncated to W bits.
- Operand contract: a[i], b[i] < QP. The result is then in [0, QP-1] with a single conditional subtraction.
  - Out-of-range operands still get one conditional subtraction only; the result is unspecified but deterministic.
- Boundaries:
  - s == QP → 0.
  - s == QP-1 → QP-1, with no subtraction.
  - QP-1 + QP-1 → QP-2.
  - All slots are computed in parallel and independently. No carries cross slots, and A and B never interact.
- Layout: CT_t is packed {A, B}, A in the upper N*W bits. Within vec_t, slot 0 occupies bits [W-1:0].

Optional Feature:
- Macro: CT_ADD_RANGE_CHK_EN.
- Defined:
  - Adds output range_err, registered alongside out_ct.
  - range_err is set at an accepted input (in_valid=1) when any of the 4N input coefficients is ≥ QP.
  - range_err is cleared on the next accepted in-range input, and by reset.
  - Datapath results are unchanged.
- Undefined: the port and the checking logic are absent.

Decomposition:
- Package ct_pkg holds:
  - constants N_SLOTS_L=8, W_BITS_L=16, Q_MOD=7710, T_MOD=257, DELTA=30;
  - typedef vec_t = N_SLOTS_L × W_BITS_L packed array;
  - typedef CT_t = packed struct {vec_t A; vec_t B;}.
- Sub-module mod_add #(W, QP): combinational single-slot (a+b) mod QP.
  - Instantiated 2N times via generate.
  - Reused by other modular blocks.

Test Plan:
- Fixed vector, in_valid=1, QP=7710:
  - in1.A={1429,4717,6311,3279,7215,6215,6931,973}, in2.A={1081,592,951,5762,2873,4,152,3013} → out.A={2510,5309,7262,1331,2378,6219,7083,3986}.
  - in1.B={7531,4381,1094,7529,5909,964,5576,4640}, in2.B={1577,3917,6039,6187,2056,6280,1531,7656} → out.B={1398,588,7133,6006,255,7244,7107,4586}.
  - out_valid=1 one cycle later.
- Wrap edges, all slots:
  - 7709+1 → 0.
  - 7709+0 → 7709.
  - 7709+7709 → 7708.
  - 3855+3855 → 0.
  - 0+0 → 0.
- Handshake:
  - in_valid pattern 1,1,0,1 with distinct data → out_valid 1,1,0,1 one cycle delayed, correct data each time.
  - out_ct holds its value during the 0 cycle.
- Reset:
  - rst=1 with in_valid=1 and nonzero data → out_ct=0, out_valid=0 after the edge.
  - rst asserted the cycle after a valid input → the pending result is suppressed.
- With CT_ADD_RANGE_CHK_EN:
  - in1.A[3]=7710 → range_err=1 next cycle.
  - A following all-in-range input → range_err=0.
